// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl
//   I2C target on a shared SCL/SDA bus. SCL and SDA are oversampled on clk
//   (clk must be at least 8x the SCL rate). The block detects START, repeated
//   START and STOP, answers a single fixed 7-bit address, delivers written
//   bytes on the rx port and fetches read bytes from the tx port. SDA is only
//   ever pulled low (open-drain enable); SCL is never driven.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active low
//   scl_i     SCL pad input (asynchronous)
//   sda_i     SDA pad input (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   rx_data   last byte written by the master
//   rx_valid  one-cycle pulse when rx_data is updated
//   rx_ready  user can take a byte; low at byte end gives NACK and drops it
//   tx_data   next byte for a read, captured while tx_req is high
//   tx_req    one-cycle pulse in the cycle tx_data is captured
//   rd_wr     R/W bit of the last matched address (1 = read)
//   busy      high whenever the controller is not idle
//   stop_det  one-cycle pulse on every STOP seen on the bus
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rd_wr,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [2:0] count, count_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       phase, phase_n;
  logic       ack_ok, ack_ok_n;
  logic       sda_oe_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n;
  logic       tx_req_n;
  logic       rd_wr_n;
  logic       stop_det_n;

  // Synchronizer stages p0/p1, edge-detect delay p2
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_cond, stop_cond;
  logic [7:0] shift_in;
  logic addr_match;

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign sda_rise   = sda_p1 & ~sda_p2;
  assign sda_fall   = ~sda_p1 & sda_p2;
  assign start_cond = sda_fall & scl_p1;
  assign stop_cond  = sda_rise & scl_p1;
  assign shift_in   = {shift[6:0], sda_p1};

  // General call (0) and the 10-bit prefix 11110xx never match.
  assign addr_match = (shift_in[7:1] == SLAVE_ADDR) &&
                      (shift_in[7:1] != 7'd0) &&
                      (shift_in[7:3] != 5'b11110);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= 3'd0;
      shift    <= 8'd0;
      tx_shift <= 8'd0;
      phase    <= 1'b0;
      ack_ok   <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rd_wr    <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      shift    <= shift_n;
      tx_shift <= tx_shift_n;
      phase    <= phase_n;
      ack_ok   <= ack_ok_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      rd_wr    <= rd_wr_n;
      stop_det <= stop_det_n;
    end
  end

  // phase is a per-state sub-step flag:
  //   ADDR_ACK : ACK is being driven (second scl_fall leaves the state)
  //   WR_DATA  : all 8 bits received, waiting for the scl_fall to answer
  //   RD_ACK   : master ACK seen, next scl_fall starts the next byte
  always_comb begin
    state_n    = state;
    count_n    = count;
    shift_n    = shift;
    tx_shift_n = tx_shift;
    phase_n    = phase;
    ack_ok_n   = ack_ok;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    rd_wr_n    = rd_wr;
    stop_det_n = 1'b0;

    if (stop_cond) begin
      state_n    = IDLE;
      count_n    = 3'd0;
      phase_n    = 1'b0;
      sda_oe_n   = 1'b0;
      stop_det_n = 1'b1;
    end else if (start_cond) begin
      // Repeated START discards any partial byte.
      state_n  = ADDR;
      count_n  = 3'd0;
      phase_n  = 1'b0;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_n = shift_in;
            count_n = count + 3'd1;
            if (count == 3'd7) begin
              if (addr_match) begin
                rd_wr_n = shift_in[0];
                phase_n = 1'b0;
                state_n = ADDR_ACK;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else begin
              phase_n = 1'b0;
              count_n = 3'd0;
              if (rd_wr) begin
                tx_req_n   = 1'b1;
                tx_shift_n = tx_data;
                sda_oe_n   = ~tx_data[7];
                state_n    = RD_DATA;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise && !phase) begin
            shift_n = shift_in;
            count_n = count + 3'd1;
            if (count == 3'd7) begin
              phase_n = 1'b1;
            end
          end else if (scl_fall && phase) begin
            phase_n = 1'b0;
            state_n = WR_ACK;
            if (rx_ready) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              sda_oe_n   = 1'b1;
              ack_ok_n   = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              ack_ok_n = 1'b0;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ack_ok ? WR_DATA : WAIT_STOP;
          end
        end

        RD_DATA: begin
          // Entered with bit 7 already on the bus; count = bits shifted out.
          if (scl_fall) begin
            if (count == 3'd7) begin
              sda_oe_n = 1'b0;
              count_n  = 3'd0;
              phase_n  = 1'b0;
              state_n  = RD_ACK;
            end else begin
              sda_oe_n   = ~tx_shift[6];
              tx_shift_n = {tx_shift[6:0], tx_shift[7]};
              count_n    = count + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_p1) begin
              sda_oe_n = 1'b0;
              state_n  = WAIT_STOP;
            end else begin
              phase_n = 1'b1;
            end
          end else if (scl_fall && phase) begin
            phase_n    = 1'b0;
            count_n    = 3'd0;
            tx_req_n   = 1'b1;
            tx_shift_n = tx_data;
            sda_oe_n   = ~tx_data[7];
            state_n    = RD_DATA;
          end
        end

        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: a bus master drives SCL/SDA through
// an open-drain wired-AND; expected ACKs, received bytes and read data come
// from a transaction-level model of the target.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] SLAVE = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       sda_oe, rx_valid, tx_req, rd_wr, busy, stop_det;
  logic [7:0] rx_data;
  logic       sda_bus;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rd_wr    (rd_wr),
    .busy     (busy),
    .stop_det (stop_det)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus monitor
  int         rx_cnt = 0, tx_cnt = 0, stop_cnt = 0;
  int         overlap_cnt = 0, oe_viol = 0, oe_rise = 0;
  logic [7:0] rx_log [256];
  logic [7:0] tx_mem [64];
  logic       oe_prev = 1'b0;

  assign tx_data = tx_mem[tx_cnt[5:0]];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] = rx_data;
      rx_cnt++;
    end
    if (tx_req) tx_cnt++;
    if (stop_det) stop_cnt++;
    if (rx_valid && tx_req) overlap_cnt++;
    if (sda_oe !== oe_prev && scl === 1'b1) oe_viol++;
    if (sda_oe === 1'b1 && oe_prev === 1'b0) oe_rise++;
    oe_prev = sda_oe;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock; SCL is low on entry and exit. bus = SDA level mid-high.
  task automatic send_bit(input logic b, output logic bus);
    wait_clks(4); m_sda = b;
    wait_clks(4); scl = 1'b1;
    wait_clks(4); bus = sda_bus;
    wait_clks(4); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clks(4); m_sda = 1'b0;
    wait_clks(4); scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clks(4); m_sda = 1'b1;
    wait_clks(4); scl = 1'b1;
    wait_clks(4); m_sda = 1'b0;
    wait_clks(4); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(4); m_sda = 1'b0;
    wait_clks(4); scl = 1'b1;
    wait_clks(4); m_sda = 1'b1;
    wait_clks(8);
  endtask

  // Sends a byte, then releases SDA for the 9th clock; ack_bus 0 = ACK.
  task automatic xfer_byte(input logic [7:0] b, output logic ack_bus);
    logic x;
    for (int i = 7; i >= 0; i--) send_bit(b[i], x);
    send_bit(1'b1, ack_bus);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, x);
      b[i] = x;
    end
    send_bit(~mack, x);
  endtask

  logic [7:0] wd [8];
  logic       wr [8];
  logic [7:0] rb [8];

  // Write transaction. Model: the target ACKs the address only on a match,
  // then ACKs each byte while every earlier byte was ACKed and rx_ready is high.
  task automatic do_write(input logic [6:0] a, input int n, input string tag);
    logic       ack, alive, exp_ack;
    int         rx0, st0, oe0;
    logic [7:0] exp_q [$];
    rx0 = rx_cnt; st0 = stop_cnt; oe0 = oe_rise;
    i2c_start();
    xfer_byte({a, 1'b0}, ack);
    alive = (a == SLAVE);
    check({tag, "_addr_ack"}, 32'(ack), 32'(!alive));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      rx_ready = wr[k];
      xfer_byte(wd[k], ack);
      exp_ack = alive && wr[k];
      check({tag, "_data_ack"}, 32'(ack), 32'(!exp_ack));
      if (exp_ack) exp_q.push_back(wd[k]);
      alive = exp_ack;
    end
    rx_ready = 1'b1;
    i2c_stop();
    check({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check({tag, "_rx_byte"}, 32'(rx_log[8'(rx0 + k)]), 32'(exp_q[k]));
    if (exp_q.size() > 0) check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_q[exp_q.size() - 1]));
    if (a != SLAVE) check({tag, "_oe_quiet"}, 32'(oe_rise - oe0), 32'd0);
    check({tag, "_stop_det"}, 32'(stop_cnt - st0), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_released"}, 32'(sda_oe), 32'd0);
  endtask

  // Read transaction: master ACKs every byte but the last, which it NACKs.
  task automatic do_read(input logic [6:0] a, input int n, input string tag);
    logic       ack;
    logic [7:0] b;
    int         base, tx0, rx0, st0;
    base = tx_cnt; tx0 = tx_cnt; rx0 = rx_cnt; st0 = stop_cnt;
    for (int k = 0; k < n; k++) tx_mem[6'(base + k)] = rb[k];
    i2c_start();
    xfer_byte({a, 1'b1}, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(a != SLAVE));
    if (a == SLAVE) begin
      for (int k = 0; k < n; k++) begin
        read_byte(k < n - 1, b);
        check({tag, "_rd_byte"}, 32'(b), 32'(rb[k]));
      end
      check({tag, "_rd_wr"}, 32'(rd_wr), 32'd1);
    end
    i2c_stop();
    check({tag, "_tx_req_count"}, 32'(tx_cnt - tx0), (a == SLAVE) ? 32'(n) : 32'd0);
    check({tag, "_no_rx"}, 32'(rx_cnt - rx0), 32'd0);
    check({tag, "_stop_det"}, 32'(stop_cnt - st0), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_released"}, 32'(sda_oe), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic       x;
    logic [7:0] b;
    logic [7:0] part;
    int         tx0, rx0;
    logic [6:0] a;
    int         n;

    for (int i = 0; i < 64; i++) tx_mem[i] = 8'(i * 37 + 11);

    // Reset state
    wait_clks(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_rd_wr", 32'(rd_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stop_det", 32'(stop_det), 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // Single-byte write
    wd[0] = 8'h5A; wr[0] = 1'b1;
    do_write(SLAVE, 1, "wr_5a");

    // Two-byte read, ACK then NACK
    rb[0] = 8'hA5; rb[1] = 8'h3C;
    do_read(SLAVE, 2, "rd_a53c");

    // Wrong address: data ignored, SDA never pulled
    wd[0] = 8'h00; wd[1] = 8'hFF; wr[0] = 1'b1; wr[1] = 1'b1;
    do_write(7'h51, 2, "wr_51");

    // rx_ready low on the second byte
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    wr[0] = 1'b1; wr[1] = 1'b0; wr[2] = 1'b1;
    do_write(SLAVE, 3, "wr_nack");

    // General call is not answered
    wd[0] = 8'h06; wr[0] = 1'b1;
    do_write(7'h00, 1, "gcall");

    // Repeated START after 4 bits of a data byte, then a read
    tx0 = tx_cnt; rx0 = rx_cnt;
    tx_mem[6'(tx_cnt)] = 8'hC3;
    i2c_start();
    xfer_byte({SLAVE, 1'b0}, ack);
    check("rs_addr_w_ack", 32'(ack), 32'd0);
    part = 8'(($urandom));
    for (int i = 7; i >= 4; i--) send_bit(part[i], x);
    i2c_rstart();
    xfer_byte({SLAVE, 1'b1}, ack);
    check("rs_addr_r_ack", 32'(ack), 32'd0);
    check("rs_rd_wr", 32'(rd_wr), 32'd1);
    read_byte(1'b0, b);
    check("rs_rd_byte", 32'(b), 32'hC3);
    i2c_stop();
    check("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("rs_tx_req", 32'(tx_cnt - tx0), 32'd1);

    // Reset while driving a 0 bit in a read
    tx_mem[6'(tx_cnt)] = 8'h00;
    i2c_start();
    xfer_byte({SLAVE, 1'b1}, ack);
    check("rr_addr_ack", 32'(ack), 32'd0);
    wait_clks(5);
    check("rr_driving_zero", 32'(sda_oe), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rr_oe_async", 32'(sda_oe), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_rd_wr", 32'(rd_wr), 32'd0);
    check("rr_rx_data", 32'(rx_data), 32'd0);
    check("rr_tx_req", 32'(tx_req), 32'd0);
    wait_clks(2);
    m_sda = 1'b1;
    wait_clks(2);
    scl = 1'b1;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(6);
    wd[0] = 8'h96; wr[0] = 1'b1;
    do_write(SLAVE, 1, "rr_clean_wr");

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: a = SLAVE;
        3:       a = 7'h00;
        default: a = 7'($urandom_range(1, 127));
      endcase
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        wd[k] = 8'($urandom);
        rb[k] = 8'($urandom);
        wr[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 1) == 0) do_write(a, n, "rand_wr");
      else do_read(a, n, "rand_rd");
    end

    check("no_rx_tx_overlap", 32'(overlap_cnt), 32'd0);
    check("oe_only_scl_low", 32'(oe_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
